rs_stream_encoder: RTL and testbench

Streaming systematic Reed-Solomon encoder over GF(2^4) (primitive polynomial x^4+x+1, alpha = 4'b0010), parametrised in code length and parity count. It replaces the single-shot, fully parallel RS(15,9) encoder with a symbol-serial LFSR datapath that has valid/ready handshakes on both sides. It sits between the message source and the channel/error-injection path, and feeds the decoder one 4-bit symbol per cycle.

---
 rtl/rs_stream_encoder.sv | 127 ++++++++++++
 tb/tb_rs_stream_encoder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_stream_encoder.sv
// Symbol-serial systematic Reed-Solomon encoder over GF(2^4) (x^4+x+1).
// Message symbols stream straight through; the LFSR remainder follows as N-K parity symbols.
module rs_stream_encoder #(
  parameter int N = 15,
  parameter int K = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       enc_busy
);

  localparam int NK    = N - K;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [0:0] ST_MSG = 1'b0;
  localparam logic [0:0] ST_PAR = 1'b1;

  localparam logic [CNT_W-1:0] MSG_END = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] PAR_END = CNT_W'(NK - 1);

  function automatic logic [3:0] gfMul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'h0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  // Generator coefficients packed 4 bits per degree, g[j] at [4j+:4]; built as prod (x + alpha^i).
  function automatic logic [63:0] genPoly();
    logic [63:0] g;
    logic [3:0]  root;
    logic [3:0]  lower;
    g    = 64'h1;
    root = 4'h1;
    for (int i = 1; i <= NK; i++) begin
      root = gfMul(root, 4'h2);
      for (int j = NK; j >= 0; j--) begin
        lower = (j > 0) ? g[4*(j-1) +: 4] : 4'h0;
        g[4*j +: 4] = lower ^ gfMul(root, g[4*j +: 4]);
      end
    end
    return g;
  endfunction

  localparam logic [63:0] GEN = genPoly();

  logic [0:0]        state;
  logic [CNT_W-1:0]  symCnt;
  logic [4*NK-1:0]   parity;
  logic [4*NK-1:0]   parNext;
  logic [3:0]        fb;
  logic [3:0]        data_p0;
  logic              vld_p0;
  logic              last_p0;
  logic              outSlot;
  logic              accept;

  assign outSlot  = !vld_p0 || out_ready;
  assign in_ready = (state == ST_MSG) && outSlot;
  assign accept   = in_valid && in_ready;

  always_comb begin
    parNext = '0;
    fb      = in_data ^ parity[4*NK-1 -: 4];
    parNext[3:0] = gfMul(GEN[3:0], fb);
    for (int j = 1; j < NK; j++) begin
      parNext[4*j +: 4] = parity[4*(j-1) +: 4] ^ gfMul(GEN[4*j +: 4], fb);
    end
  end

  // Output stage p0: message echo in MSG, remainder drained high-degree first in PAR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_MSG;
      symCnt  <= '0;
      parity  <= '0;
      data_p0 <= 4'h0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else if (state == ST_MSG) begin
      if (accept) begin
        data_p0 <= in_data;
        vld_p0  <= 1'b1;
        last_p0 <= 1'b0;
        parity  <= parNext;
        if (symCnt == MSG_END) begin
          symCnt <= '0;
          state  <= ST_PAR;
        end else begin
          symCnt <= symCnt + CNT_W'(1);
        end
      end else if (outSlot) begin
        vld_p0  <= 1'b0;
        last_p0 <= 1'b0;
      end
    end else if (outSlot) begin
      data_p0 <= parity[4*NK-1 -: 4];
      vld_p0  <= 1'b1;
      last_p0 <= (symCnt == PAR_END);
      parity  <= {parity[4*NK-5:0], 4'h0};
      if (symCnt == PAR_END) begin
        symCnt <= '0;
        state  <= ST_MSG;
      end else begin
        symCnt <= symCnt + CNT_W'(1);
      end
    end
  end

  assign out_data  = data_p0;
  assign out_valid = vld_p0;
  assign out_last  = last_p0;
  assign enc_busy  = (state == ST_PAR) || (symCnt != '0) || vld_p0;

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Scoreboard bench for rs_stream_encoder: three instances (15,13), (15,9), (10,6) checked
// against a long-division RS model plus syndrome evaluation of every received codeword.
module tb_rs_stream_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [3:0] gexp [15];
  int         glog [16];

  initial begin
    logic [3:0] e;
    e = 4'h1;
    glog[0] = 0;
    for (int i = 0; i < 15; i++) begin
      gexp[i] = e;
      glog[e] = i;
      e = {e[2:0], 1'b0} ^ (e[3] ? 4'h3 : 4'h0);
    end
  end

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    if (a == 4'h0 || b == 4'h0) return 4'h0;
    return gexp[(glog[a] + glog[b]) % 15];
  endfunction

  task automatic check(input int unitId, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL unit%0d %s: got %0h, expected %0h at %0t", unitId, name, act, exp, $time);
    end
  endtask

  for (genvar u = 0; u < 3; u++) begin : unit
    localparam int NN   = (u == 2) ? 10 : 15;
    localparam int KK   = (u == 0) ? 13 : ((u == 1) ? 9 : 6);
    localparam int PP   = NN - KK;
    localparam int NMSG = (u == 1) ? 200 : 40;

    logic       rst = 1'b1;
    logic [3:0] inData = 4'h0;
    logic       inValid = 1'b0;
    logic       inReady;
    logic [3:0] outData;
    logic       outValid;
    logic       outReady = 1'b1;
    logic       outLast;
    logic       encBusy;

    rs_stream_encoder #(.N(NN), .K(KK)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (inData),
      .in_valid (inValid),
      .in_ready (inReady),
      .out_data (outData),
      .out_valid(outValid),
      .out_ready(outReady),
      .out_last (outLast),
      .enc_busy (encBusy)
    );

    logic [4:0] expQ [$];
    logic [3:0] rx [$];
    int  rdyMode = 0;
    bit  done = 1'b0;
    bit  burst = 1'b0;
    int  cyc = 0;
    int  firstX = -1;
    int  lastX = -1;
    int  acc = 0;
    int  xfer = 0;
    logic [3:0] msg [16];

    // Reference: remainder of m(x)x^PP by g(x) via polynomial long division.
    task automatic pushModel(input logic [3:0] m [16]);
      logic [3:0] g [16];
      logic [3:0] rem [16];
      logic [3:0] q;
      logic [3:0] r;
      for (int i = 0; i < 16; i++) begin
        g[i] = 4'h0;
        rem[i] = 4'h0;
      end
      g[0] = 4'h1;
      for (int i = 1; i <= PP; i++) begin
        r = gexp[i % 15];
        for (int j = PP; j >= 1; j--) g[j] = g[j-1] ^ gmul(r, g[j]);
        g[0] = gmul(r, g[0]);
      end
      for (int i = 0; i < KK; i++) rem[NN-1-i] = m[i];
      for (int d = NN - 1; d >= PP; d--) begin
        q = rem[d];
        for (int j = 0; j <= PP; j++) rem[d-PP+j] = rem[d-PP+j] ^ gmul(q, g[j]);
      end
      for (int i = 0; i < KK; i++) expQ.push_back({1'b0, m[i]});
      for (int d = PP - 1; d >= 0; d--) expQ.push_back({(d == 0), rem[d]});
    endtask

    task automatic sendSymbols(input logic [3:0] m [16], input int cnt, input bit gaps, input bit keep);
      int w;
      for (int i = 0; i < cnt; i++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          inValid = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        inValid = 1'b1;
        inData  = m[i];
        w = 0;
        @(negedge clk);
        while (!inReady && w < 500) begin
          w++;
          @(negedge clk);
        end
        if (!inReady) begin
          checks++;
          errors++;
          $display("FAIL unit%0d accept timeout: in_ready 0 for %0d cycles, expected 1", u, w);
        end
        @(posedge clk);
        #1;
      end
      if (!keep) inValid = 1'b0;
    endtask

    task automatic drain();
      int w;
      w = 0;
      while (expQ.size() != 0 && w < 3000) begin
        @(negedge clk);
        w++;
      end
      check(u, "drain queue", expQ.size(), 0);
      @(posedge clk);
      #1;
    endtask

    task automatic randMsg();
      for (int i = 0; i < 16; i++) msg[i] = 4'($urandom_range(0, 15));
    endtask

    initial forever begin
      @(posedge clk);
      #1;
      outReady = (rdyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Monitor: protocol model from handshake counts, scoreboard pop, syndromes.
    initial begin
      bit         stallPrev;
      logic [3:0] prevData;
      logic       prevLast;
      logic [4:0] e5;
      logic [3:0] s;
      int         loaded;
      int         cw;
      bit         inPar;
      stallPrev = 1'b0;
      prevData  = 4'h0;
      prevLast  = 1'b0;
      forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
          acc = 0;
          xfer = 0;
          stallPrev = 1'b0;
          rx.delete();
        end else begin
          loaded = xfer + int'(outValid);
          cw     = acc / KK;
          inPar  = (loaded - acc) < cw * PP;
          check(u, "in_ready", int'(inReady), int'(!inPar && (!outValid || outReady)));
          check(u, "enc_busy", int'(encBusy), int'(inPar || (acc % KK != 0) || outValid));
          if (stallPrev) begin
            check(u, "hold valid", int'(outValid), 1);
            check(u, "hold data", int'(outData), int'(prevData));
            check(u, "hold last", int'(outLast), int'(prevLast));
          end
          if (outValid && outReady) begin
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unit%0d extra output: got %0h, expected no symbol", u, outData);
            end else begin
              e5 = expQ.pop_front();
              check(u, "out_data", int'(outData), int'(e5[3:0]));
              check(u, "out_last", int'(outLast), int'(e5[4]));
              rx.push_back(outData);
              if (e5[4]) begin
                for (int i = 1; i <= PP; i++) begin
                  s = 4'h0;
                  foreach (rx[k]) s = gmul(s, gexp[i]) ^ rx[k];
                  check(u, $sformatf("syndrome S%0d", i), int'(s), 0);
                end
                rx.delete();
              end
            end
            if (burst) begin
              if (firstX < 0) firstX = cyc;
              lastX = cyc;
            end
            xfer++;
          end
          stallPrev = outValid && !outReady;
          prevData  = outData;
          prevLast  = outLast;
          if (inValid && inReady) acc++;
        end
      end
    end

    // Stimulus
    initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check(u, "reset out_valid", int'(outValid), 0);
      check(u, "reset out_last", int'(outLast), 0);
      check(u, "reset out_data", int'(outData), 0);
      check(u, "reset enc_busy", int'(encBusy), 0);
      check(u, "reset in_ready", int'(inReady), 1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 16; i++) msg[i] = 4'h0;
      if (u == 0) begin
        msg[KK-1] = 4'h1;
        for (int i = 0; i < KK; i++) expQ.push_back({1'b0, msg[i]});
        expQ.push_back(5'h06);
        expQ.push_back(5'h18);
        sendSymbols(msg, KK, 1'b0, 1'b0);
      end else begin
        pushModel(msg);
        sendSymbols(msg, KK, 1'b0, 1'b0);
        msg[KK-2] = 4'hE;
        pushModel(msg);
        sendSymbols(msg, KK, 1'b0, 1'b0);
      end
      drain();

      // Reset after five accepted symbols, then the same message in full.
      randMsg();
      for (int i = 0; i < 5; i++) expQ.push_back({1'b0, msg[i]});
      sendSymbols(msg, 5, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check(u, "busy mid-codeword", int'(encBusy), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check(u, "post-reset out_valid", int'(outValid), 0);
      check(u, "post-reset enc_busy", int'(encBusy), 0);
      check(u, "post-reset out_last", int'(outLast), 0);
      check(u, "post-reset queue", expQ.size(), 0);
      @(posedge clk);
      #1;
      pushModel(msg);
      sendSymbols(msg, KK, 1'b0, 1'b0);
      drain();

      rdyMode = 1;
      for (int n = 0; n < NMSG; n++) begin
        randMsg();
        pushModel(msg);
        sendSymbols(msg, KK, 1'b1, 1'b0);
      end
      rdyMode = 0;
      drain();

      burst  = 1'b1;
      firstX = -1;
      for (int n = 0; n < 3; n++) begin
        randMsg();
        pushModel(msg);
        sendSymbols(msg, KK, 1'b0, (n < 2));
      end
      drain();
      burst = 1'b0;
      check(u, "back-to-back output span", lastX - firstX + 1, 3 * NN);
      done = 1'b1;
    end
  end

  initial begin
    wait (unit[0].done && unit[1].done && unit[2].done);
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
